updn_counter_p: RTL and testbench

UPDN_COUNTER_P -- requirements
Module: updn_counter_p

---
 rtl/counter_pkg.sv | 20 ++
 rtl/counter_next.sv | 85 ++++++++
 rtl/updn_counter_p.sv | 123 ++++++++++++
 tb/tb_updn_counter_p.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// -----------------------------------------------------------------------------
// counter_pkg
// Shared definitions for the up/down counter slice.
//   MODE_WRAP / MODE_SAT : encodings of the 'mode' input
//   sel_e                : which source feeds the count register in a cycle
// -----------------------------------------------------------------------------
package counter_pkg;

   localparam logic MODE_WRAP = 1'b0;
   localparam logic MODE_SAT  = 1'b1;

   // The four sources in priority order, highest first.
   typedef enum logic [1:0] {
      SEL_CFG   = 2'd0,
      SEL_LOAD  = 2'd1,
      SEL_COUNT = 2'd2,
      SEL_HOLD  = 2'd3
   } sel_e;

endpackage

// File: rtl/counter_next.sv
// -----------------------------------------------------------------------------
// counter_next
// Purely combinational next-value and event arithmetic for updn_counter_p.
// Ports:
//   i_cur        current count
//   i_direction  1 = up, 0 = down
//   i_mode       MODE_WRAP or MODE_SAT
//   i_step       increment magnitude (0 = hold)
//   i_limit_lo   inclusive lower bound
//   i_limit_hi   inclusive upper bound
//   i_load_val   raw load value
//   o_next       count result if a count is performed this cycle
//   o_event      wrap/saturation event accompanying o_next
//   o_load_clamp i_load_val clamped into [i_limit_lo, i_limit_hi]
// -----------------------------------------------------------------------------
module counter_next
   import counter_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] i_cur,
   input  logic             i_direction,
   input  logic             i_mode,
   input  logic [WIDTH-1:0] i_step,
   input  logic [WIDTH-1:0] i_limit_lo,
   input  logic [WIDTH-1:0] i_limit_hi,
   input  logic [WIDTH-1:0] i_load_val,
   output logic [WIDTH-1:0] o_next,
   output logic             o_event,
   output logic [WIDTH-1:0] o_load_clamp
);

   logic [WIDTH:0] w_sum;
   logic [WIDTH:0] w_diff;
   logic           w_carry;
   logic           w_borrow;

   // One extra bit catches carry-out on the sum and borrow on the difference.
   assign w_sum    = {1'b0, i_cur} + {1'b0, i_step};
   assign w_diff   = {1'b0, i_cur} - {1'b0, i_step};
   assign w_carry  = w_sum[WIDTH];
   assign w_borrow = w_diff[WIDTH];

   // Count result. A count that starts outside the window (limits moved at
   // run time) is pulled back to the violated bound first, even with step 0.
   // Landing exactly on a bound is a normal count, not an event.
   always_comb begin
      o_next  = i_cur;
      o_event = 1'b0;
      if (i_cur > i_limit_hi) begin
         o_next  = i_limit_hi;
         o_event = 1'b1;
      end else if (i_cur < i_limit_lo) begin
         o_next  = i_limit_lo;
         o_event = 1'b1;
      end else if (i_step == '0) begin
         o_next  = i_cur;
      end else if (i_direction) begin
         if (w_carry || (w_sum[WIDTH-1:0] > i_limit_hi)) begin
            o_next  = (i_mode == MODE_SAT) ? i_limit_hi : i_limit_lo;
            o_event = 1'b1;
         end else begin
            o_next  = w_sum[WIDTH-1:0];
         end
      end else begin
         if (w_borrow || (w_diff[WIDTH-1:0] < i_limit_lo)) begin
            o_next  = (i_mode == MODE_SAT) ? i_limit_lo : i_limit_hi;
            o_event = 1'b1;
         end else begin
            o_next  = w_diff[WIDTH-1:0];
         end
      end
   end

   // Loads never leave the window.
   always_comb begin
      o_load_clamp = i_load_val;
      if (i_load_val < i_limit_lo) begin
         o_load_clamp = i_limit_lo;
      end else if (i_load_val > i_limit_hi) begin
         o_load_clamp = i_limit_hi;
      end
   end

endmodule

// File: rtl/updn_counter_p.sv
// -----------------------------------------------------------------------------
// updn_counter_p
// Parameterised up/down counter with programmable window, wrap or saturate
// behaviour, synchronous load and configuration-error flag. All outputs are
// registered.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   enable, direction  count request and direction (1 = up)
//   mode               MODE_WRAP / MODE_SAT
//   step               increment magnitude
//   limit_lo/limit_hi  inclusive window
//   load, load_val     synchronous load (clamped into the window)
//   counter_out        count
//   at_hi, at_lo       count equals the respective limit
//   wrap_p             one-cycle pulse on a wrap/saturation event
//   cfg_err            limit_lo > limit_hi
// -----------------------------------------------------------------------------
module updn_counter_p
   import counter_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int RST_VAL = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             direction,
   input  logic             mode,
   input  logic [WIDTH-1:0] step,
   input  logic [WIDTH-1:0] limit_lo,
   input  logic [WIDTH-1:0] limit_hi,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] counter_out,
   output logic             at_hi,
   output logic             at_lo,
   output logic             wrap_p,
   output logic             cfg_err
);

   localparam logic [WIDTH-1:0] RST_CNT = RST_VAL[WIDTH-1:0];

   logic [WIDTH-1:0] r_count;
   logic             r_at_hi;
   logic             r_at_lo;
   logic             r_wrap;
   logic             r_cfg_err;

   logic [WIDTH-1:0] w_count_next;
   logic             w_count_event;
   logic [WIDTH-1:0] w_load_clamp;
   logic             w_cfg_bad;
   sel_e             w_sel;
   logic [WIDTH-1:0] w_nxt;
   logic             w_wrap;

   counter_next #(
      .WIDTH (WIDTH)
   ) u_next (
      .i_cur        (r_count),
      .i_direction  (direction),
      .i_mode       (mode),
      .i_step       (step),
      .i_limit_lo   (limit_lo),
      .i_limit_hi   (limit_hi),
      .i_load_val   (load_val),
      .o_next       (w_count_next),
      .o_event      (w_count_event),
      .o_load_clamp (w_load_clamp)
   );

   assign w_cfg_bad = (limit_lo > limit_hi);

   // Priority: bad configuration freezes the count, then load, then count.
   always_comb begin
      w_sel = SEL_HOLD;
      if (w_cfg_bad) begin
         w_sel = SEL_CFG;
      end else if (load) begin
         w_sel = SEL_LOAD;
      end else if (enable) begin
         w_sel = SEL_COUNT;
      end
   end

   always_comb begin
      w_nxt  = r_count;
      w_wrap = 1'b0;
      unique case (w_sel)
         SEL_LOAD:  w_nxt = w_load_clamp;
         SEL_COUNT: begin
            w_nxt  = w_count_next;
            w_wrap = w_count_event;
         end
         default:   w_nxt = r_count;
      endcase
   end

   // Flags are derived from the value being written, so they line up with
   // counter_out on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count   <= RST_CNT;
         r_at_hi   <= 1'b0;
         r_at_lo   <= 1'b0;
         r_wrap    <= 1'b0;
         r_cfg_err <= 1'b0;
      end else begin
         r_count   <= w_nxt;
         r_at_hi   <= (w_nxt == limit_hi);
         r_at_lo   <= (w_nxt == limit_lo);
         r_wrap    <= w_wrap;
         r_cfg_err <= w_cfg_bad;
      end
   end

   assign counter_out = r_count;
   assign at_hi       = r_at_hi;
   assign at_lo       = r_at_lo;
   assign wrap_p      = r_wrap;
   assign cfg_err     = r_cfg_err;

endmodule

// File: tb/tb_updn_counter_p.sv
// -----------------------------------------------------------------------------
// tb_updn_counter_p
// Self-checking bench for updn_counter_p (WIDTH=8, RST_VAL=0). Each driven
// cycle pushes a model-predicted result into a queue; the result is popped
// and compared one time unit after the following rising edge.
// -----------------------------------------------------------------------------
module tb_updn_counter_p;

   typedef struct {
      int cnt;
      int hi;
      int lo;
      int wrp;
      int cfg;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic       enable;
   logic       direction;
   logic       mode;
   logic [7:0] step;
   logic [7:0] limit_lo;
   logic [7:0] limit_hi;
   logic       load;
   logic [7:0] load_val;
   logic [7:0] counter_out;
   logic       at_hi;
   logic       at_lo;
   logic       wrap_p;
   logic       cfg_err;

   int   checks;
   int   failures;
   int   mCnt;
   exp_t expQ[$];

   updn_counter_p #(
      .WIDTH   (8),
      .RST_VAL (0)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (enable),
      .direction   (direction),
      .mode        (mode),
      .step        (step),
      .limit_lo    (limit_lo),
      .limit_hi    (limit_hi),
      .load        (load),
      .load_val    (load_val),
      .counter_out (counter_out),
      .at_hi       (at_hi),
      .at_lo       (at_lo),
      .wrap_p      (wrap_p),
      .cfg_err     (cfg_err)
   );

   // 10-unit clock period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point for the whole bench.
   task automatic checkOutput(input string tag, input int observed, input int expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Reference behaviour written directly from the counter's description,
   // using plain integer arithmetic.
   function automatic exp_t predict(input int en, input int dir, input int md,
                                    input int stp, input int lo, input int hi,
                                    input int ld, input int ldv);
      exp_t e;
      int   n;
      int   w;
      n = mCnt;
      w = 0;
      e.cfg = (lo > hi) ? 1 : 0;
      if (lo > hi) begin
         n = mCnt;
      end else if (ld != 0) begin
         n = (ldv < lo) ? lo : ((ldv > hi) ? hi : ldv);
      end else if (en != 0) begin
         if (mCnt > hi) begin
            n = hi; w = 1;
         end else if (mCnt < lo) begin
            n = lo; w = 1;
         end else if (stp == 0) begin
            n = mCnt;
         end else if (dir != 0) begin
            if (mCnt + stp > hi) begin
               n = (md != 0) ? hi : lo; w = 1;
            end else begin
               n = mCnt + stp;
            end
         end else begin
            if (mCnt - stp < lo) begin
               n = (md != 0) ? lo : hi; w = 1;
            end else begin
               n = mCnt - stp;
            end
         end
      end
      e.cnt = n;
      e.wrp = w;
      e.hi  = (n == hi) ? 1 : 0;
      e.lo  = (n == lo) ? 1 : 0;
      return e;
   endfunction

   // Drive one cycle of inputs, queue the prediction, then score the DUT
   // one time unit after the edge.
   task automatic applyStimulus(input string tag, input int en, input int dir,
                                input int md, input int stp, input int lo,
                                input int hi, input int ld, input int ldv);
      exp_t e;
      enable    = en[0];
      direction = dir[0];
      mode      = md[0];
      step      = stp[7:0];
      limit_lo  = lo[7:0];
      limit_hi  = hi[7:0];
      load      = ld[0];
      load_val  = ldv[7:0];
      e = predict(en, dir, md, stp, lo, hi, ld, ldv);
      mCnt = e.cnt;
      expQ.push_back(e);
      @(posedge clk);
      #1;
      e = expQ.pop_front();
      checkOutput({tag, ".cnt"}, int'(counter_out), e.cnt);
      checkOutput({tag, ".at_hi"}, int'(at_hi), e.hi);
      checkOutput({tag, ".at_lo"}, int'(at_lo), e.lo);
      checkOutput({tag, ".wrap"}, int'(wrap_p), e.wrp);
      checkOutput({tag, ".cfg"}, int'(cfg_err), e.cfg);
   endtask

   task automatic checkReset(input string tag);
      checkOutput({tag, ".cnt"}, int'(counter_out), 0);
      checkOutput({tag, ".at_hi"}, int'(at_hi), 0);
      checkOutput({tag, ".at_lo"}, int'(at_lo), 0);
      checkOutput({tag, ".wrap"}, int'(wrap_p), 0);
      checkOutput({tag, ".cfg"}, int'(cfg_err), 0);
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      mCnt      = 0;
      rst_n     = 1'b0;
      enable    = 1'b1;
      direction = 1'b1;
      mode      = 1'b0;
      step      = 8'd1;
      limit_lo  = 8'd0;
      limit_hi  = 8'd255;
      load      = 1'b0;
      load_val  = 8'd0;

      // Reset state, before and after an edge under reset.
      #1;
      checkReset("rst0");
      @(posedge clk);
      #1;
      checkReset("rst1");
      @(negedge clk);
      rst_n = 1'b1;
      #1;

      // Basic up count 1, 2, 3.
      for (int i = 0; i < 3; i++) begin
         applyStimulus("up", 1, 1, 0, 1, 0, 255, 0, 0);
      end

      // Window 10/20, WRAP: 18 + 3 wraps to 10, then 10 - 1 wraps to 20.
      applyStimulus("ld18", 0, 1, 0, 3, 10, 20, 1, 18);
      applyStimulus("wrapUp", 1, 1, 0, 3, 10, 20, 0, 0);
      applyStimulus("wrapDn", 1, 0, 0, 1, 10, 20, 0, 0);

      // SATURATE: 19 + 5 pins at 20 on two edges.
      applyStimulus("ld19", 0, 1, 1, 5, 10, 20, 1, 19);
      applyStimulus("sat1", 1, 1, 1, 5, 10, 20, 0, 0);
      applyStimulus("sat2", 1, 1, 1, 5, 10, 20, 0, 0);

      // Exact landing on a bound is not an event; saturate at lower bound.
      applyStimulus("ld13", 0, 0, 1, 3, 10, 20, 1, 13);
      applyStimulus("landLo", 1, 0, 1, 3, 10, 20, 0, 0);
      applyStimulus("satLo", 1, 0, 1, 3, 10, 20, 0, 0);
      applyStimulus("step0", 1, 1, 0, 0, 10, 20, 0, 0);

      // Load beats count and is clamped.
      applyStimulus("ldClamp", 1, 1, 0, 1, 0, 100, 1, 200);

      // Count outside a moved window clamps to the violated bound.
      applyStimulus("outside", 1, 1, 0, 0, 10, 20, 0, 0);

      // Bad configuration holds and flags; restoring clears it.
      applyStimulus("cfgBad", 1, 1, 0, 1, 50, 40, 0, 0);
      applyStimulus("cfgBadLd", 1, 1, 0, 1, 50, 40, 1, 45);
      applyStimulus("cfgOk", 1, 1, 0, 1, 0, 255, 0, 0);

      // Carry out of 8 bits: 250 + 10 wraps to 0.
      applyStimulus("ld250", 0, 1, 0, 10, 0, 255, 1, 250);
      applyStimulus("carry", 1, 1, 0, 10, 0, 255, 0, 0);
      applyStimulus("ld5", 0, 1, 0, 10, 0, 255, 1, 5);
      applyStimulus("borrow", 1, 0, 1, 10, 0, 255, 0, 0);

      // Asynchronous reset mid-cycle with a load pending.
      applyStimulus("ld77", 0, 1, 0, 1, 0, 255, 1, 77);
      load     = 1'b1;
      load_val = 8'd99;
      #2;
      rst_n = 1'b0;
      #1;
      checkReset("asyncRst");
      @(posedge clk);
      #1;
      checkReset("rstHeld");
      @(negedge clk);
      rst_n = 1'b1;
      mCnt  = 0;
      applyStimulus("afterRst", 1, 1, 0, 2, 0, 255, 0, 0);

      // Randomised traffic in a small window, occasionally misconfigured.
      for (int i = 0; i < 60; i++) begin
         applyStimulus("rand", int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                       int'($urandom_range(0, 1)), int'($urandom_range(0, 6)),
                       int'($urandom_range(0, 12)), int'($urandom_range(8, 30)),
                       ($urandom_range(0, 7) == 0) ? 1 : 0, int'($urandom_range(0, 40)));
      end

      checkOutput("queueEmpty", expQ.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
